// File: rtl/button_frontend.sv
// button_frontend: per-channel synchronizer, counter debounce and press/release pulses.
// `define COMBO_RESET_EN adds the all-held combo reset request with pulse masking.
// The release pulse port is named `released` because `release` is a reserved word.
module button_chan #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  input  logic mask,
  output logic level,
  output logic press,
  output logic released
);
  localparam int              CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt;
  logic                   s, flip;

  assign s    = ~sync_q[SYNC_STAGES-1];
  assign flip = (s != level) && (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q   <= '1;
      cnt      <= '0;
      level    <= 1'b0;
      press    <= 1'b0;
      released <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], btn_n};
      // any sample agreeing with the current level restarts qualification
      if (s == level || flip) cnt <= '0;
      else                    cnt <= cnt + CW'(1);
      if (flip) level <= s;
      press    <= flip &  s & ~mask;
      released <= flip & ~s & ~mask;
    end
  end
endmodule

module button_frontend #(
  parameter int N_CH              = 2,
  parameter int SYNC_STAGES       = 2,
  parameter int DEBOUNCE_CYCLES   = 16,
  parameter int COMBO_HOLD_CYCLES = 1024
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic [N_CH-1:0] btn_n,
  output logic [N_CH-1:0] level,
  output logic [N_CH-1:0] press,
  output logic [N_CH-1:0] released,
  output logic            combo_reset
);
  logic mask;

  if (N_CH < 1 || SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1 || COMBO_HOLD_CYCLES < 1) begin : g_param_check
    $error("button_frontend: illegal parameter value");
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    button_chan #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_chan (
      .clk     (Clk),
      .rst     (Reset),
      .btn_n   (btn_n[i]),
      .mask    (mask),
      .level   (level[i]),
      .press   (press[i]),
      .released(released[i])
    );
  end

`ifdef COMBO_RESET_EN
  typedef enum logic [1:0] {IDLE, ARMING, ACTIVE, DRAIN} combo_state_e;
  localparam int            HW        = $clog2(COMBO_HOLD_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(COMBO_HOLD_CYCLES - 1);

  combo_state_e  state, state_nxt;
  logic [HW-1:0] hold_cnt;
  logic          all_held;

  assign all_held = &level;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= IDLE;
      hold_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE)        hold_cnt <= '0;
      else if (state == ARMING) hold_cnt <= hold_cnt + HW'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (all_held) state_nxt = ARMING;
      ARMING:  if (!all_held) state_nxt = IDLE;
               else if (hold_cnt == HOLD_LAST) state_nxt = ACTIVE;
      ACTIVE:  if (!all_held) state_nxt = DRAIN;
      // wait for every button to let go so the combo exit stays silent
      DRAIN:   if (~|level) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    combo_reset = (state == ACTIVE);
    mask        = (state == ACTIVE) || (state == DRAIN);
  end
`else
  assign combo_reset = 1'b0;
  assign mask        = 1'b0;
`endif
endmodule
